// File: rtl/posit_add_arb.sv
// Round-robin front end sharing one combinational posit adder among R requesters.
// Operand register (S1) -> adder -> result register (S2) with response backpressure (es >= 1).
module posit_add_arb #(
  parameter int N   = 16,
  parameter int es  = 2,
  parameter int R   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_in1,
  input  logic [R*N-1:0] req_in2,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [N-1:0]   rsp_out,
  output logic           rsp_inf,
  output logic           rsp_zero,
  output logic [IDW-1:0] rsp_id,
  output logic [1:0]     in_flight
);
  localparam int FW = N - 1 - es;
  localparam int MW = FW + 4;
  localparam int SW = $clog2(N) + es + 3;
  localparam int SL = N + es + MW;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  typedef struct packed {
    logic [SW-1:0] scale;
    logic [FW-1:0] frac;
  } upos_t;

  typedef struct packed {
    logic [N-1:0] out;
    logic         inf;
    logic         zero;
  } sum_t;

  function automatic upos_t decode(input logic [N-2:0] mag);
    upos_t u;
    logic lead, done;
    int run, sc;
    logic [N-2:0] body;
    lead = mag[N-2];
    run  = 0;
    done = 1'b0;
    for (int i = N-2; i >= 0; i--) begin
      if (!done && mag[i] == lead) run++;
      else done = 1'b1;
    end
    body = mag << (run + 1);
    sc = (lead ? run - 1 : -run) * (1 << es) + int'(body[N-2 -: es]);
    u.scale = SW'(sc);
    u.frac  = body[FW-1:0];
    return u;
  endfunction

  // Regime/exponent/fraction packed into one string, then RNE at N-1 bits; never rounds to zero or NaR.
  function automatic logic [N-2:0] round_encode(input logic signed [SW-1:0] scale,
                                                input logic [MW-2:0] fn);
    int k, len;
    logic [es-1:0] e;
    logic [SL-1:0] str;
    logic [N-2:0] top;
    logic guard, sticky;
    k = int'(scale) >>> es;
    e = scale[es-1:0];
    if (k > N-3) return {(N-1){1'b1}};
    if (k < -(N-2)) return {{(N-2){1'b0}}, 1'b1};
    if (k >= 0) begin
      str = ~({SL{1'b1}} >> (k + 1));
      len = k + 2;
    end else begin
      str = {1'b1, {(SL-1){1'b0}}} >> (-k);
      len = 1 - k;
    end
    str    = str | ({e, fn, {(SL-es-MW+1){1'b0}}} >> len);
    top    = str[SL-1 -: N-1];
    guard  = str[SL-N];
    sticky = |str[SL-N-1:0];
    return top + (N-1)'(guard & (sticky | top[0]));
  endfunction

  function automatic sum_t posit_add(input logic [N-1:0] a, input logic [N-1:0] b);
    sum_t r;
    logic sa, sb, swap, sign;
    logic [N-1:0] ma, mb;
    upos_t ub, us;
    logic [MW-1:0] mbig, msml, s;
    logic [2*MW-1:0] ext;
    logic [N-2:0] mag;
    int d, pos, sc;
    r.inf  = (a == NAR) | (b == NAR);
    r.zero = (a == '0) & (b == '0);
    sa = a[N-1];
    sb = b[N-1];
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    swap = mb > ma;
    ub = decode(swap ? mb[N-2:0] : ma[N-2:0]);
    us = decode(swap ? ma[N-2:0] : mb[N-2:0]);
    sign = swap ? sb : sa;
    mbig = {2'b01, ub.frac, 2'b00};
    msml = {2'b01, us.frac, 2'b00};
    d = int'($signed(ub.scale)) - int'($signed(us.scale));
    if (d > MW + 1) d = MW + 1;
    // Bits shifted past the LSB are jammed into it so RNE still sees them.
    ext  = {msml, {MW{1'b0}}} >> d;
    msml = ext[2*MW-1:MW] | {{(MW-1){1'b0}}, |ext[MW-1:0]};
    s = (sa ^ sb) ? mbig - msml : mbig + msml;
    pos = 0;
    for (int i = 0; i < MW; i++) if (s[i]) pos = i;
    sc  = int'($signed(ub.scale)) + pos - (MW - 2);
    mag = round_encode(SW'(sc), (MW-1)'(s << (MW - 1 - pos)));
    if (r.inf)          r.out = NAR;
    else if (a == '0)   r.out = b;
    else if (b == '0)   r.out = a;
    else if (s == '0)   r.out = '0;
    else                r.out = sign ? -{1'b0, mag} : {1'b0, mag};
    return r;
  endfunction

  logic [IDW-1:0] ptr_q, ptr_d, gnt_id;
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [N-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s2_out_q, s2_out_d;
  logic [IDW-1:0] s1_id_q, s1_id_d, s2_id_q, s2_id_d;
  logic s2_inf_q, s2_inf_d, s2_zero_q, s2_zero_d;
  logic s1_adv, s2_adv, xfer, found;
  logic [R-1:0] grant;
  sum_t sum;
  int idx;

  always_comb begin
    s2_adv = ~s2_valid_q | rsp_ready;
    s1_adv = ~s1_valid_q | s2_adv;
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    if (s1_adv && rst_n) begin
      for (int j = 0; j < R; j++) begin
        idx = int'(ptr_q) + j;
        if (idx >= R) idx = idx - R;
        if (!found && req_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gnt_id     = IDW'(idx);
        end
      end
    end
    xfer  = found;
    ptr_d = xfer ? ((gnt_id == IDW'(R-1)) ? '0 : gnt_id + 1'b1) : ptr_q;

    // S1: operand capture
    s1_a_d     = xfer ? req_in1[gnt_id*N +: N] : s1_a_q;
    s1_b_d     = xfer ? req_in2[gnt_id*N +: N] : s1_b_q;
    s1_id_d    = xfer ? gnt_id : s1_id_q;
    s1_valid_d = xfer ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);

    // S2: adder result capture, held while the response is stalled
    sum        = posit_add(s1_a_q, s1_b_q);
    s2_out_d   = s2_adv ? sum.out    : s2_out_q;
    s2_inf_d   = s2_adv ? sum.inf    : s2_inf_q;
    s2_zero_d  = s2_adv ? sum.zero   : s2_zero_q;
    s2_id_d    = s2_adv ? s1_id_q    : s2_id_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_out_q   <= '0;
      s2_inf_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_id_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_out_q   <= s2_out_d;
      s2_inf_q   <= s2_inf_d;
      s2_zero_q  <= s2_zero_d;
      s2_id_q    <= s2_id_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
    s1_id_q <= s1_id_d;
  end

  assign req_ready = grant;
  assign rsp_valid = s2_valid_q;
  assign rsp_out   = s2_out_q;
  assign rsp_inf   = s2_inf_q;
  assign rsp_zero  = s2_zero_q;
  assign rsp_id    = s2_id_q;
  assign in_flight = 2'(s1_valid_q) + 2'(s2_valid_q);
endmodule
